// File: rtl/avalon_mem_arbiter.sv
// Two-master Avalon-MM arbiter: instruction (read-only) and data masters share one slave port.
// One transaction at a time through IDLE -> BUS -> ACK; round-robin or fixed data-priority on ties.
module avalon_mem_arbiter #(
   parameter int unsigned PRIORITY_MODE = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] m_address,
   output logic        m_read,
   output logic        m_write,
   output logic [31:0] m_writedata,
   output logic [3:0]  m_byteenable,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;
   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_ACK} state_t;

   state_t          r_state,      w_state;
   logic            r_grant,      w_grant;
   logic            r_last_grant, w_last_grant;
   logic            r_is_write,   w_is_write;
   logic [AW-1:0]   r_m_address,  w_m_address;
   logic [DW-1:0]   r_m_writedata, w_m_writedata;
   logic [BW-1:0]   r_m_byteenable, w_m_byteenable;
   logic            r_m_read,     w_m_read;
   logic            r_m_write,    w_m_write;
   logic            r_i_wait,     w_i_wait;
   logic            r_d_wait,     w_d_wait;
   logic            w_d_req;
   logic            w_win_d;

   // State and command registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_grant        <= GNT_I;
         r_last_grant   <= GNT_D;
         r_is_write     <= 1'b0;
         r_m_address    <= '0;
         r_m_writedata  <= '0;
         r_m_byteenable <= '0;
         r_m_read       <= 1'b0;
         r_m_write      <= 1'b0;
         r_i_wait       <= 1'b1;
         r_d_wait       <= 1'b1;
      end else begin
         r_state        <= w_state;
         r_grant        <= w_grant;
         r_last_grant   <= w_last_grant;
         r_is_write     <= w_is_write;
         r_m_address    <= w_m_address;
         r_m_writedata  <= w_m_writedata;
         r_m_byteenable <= w_m_byteenable;
         r_m_read       <= w_m_read;
         r_m_write      <= w_m_write;
         r_i_wait       <= w_i_wait;
         r_d_wait       <= w_d_wait;
      end
   end

   assign w_d_req = d_read | d_write;

   // Tie-break: round-robin hands the grant to the master that did not win last time
   always_comb begin
      if (i_read && w_d_req)
         w_win_d = (PRIORITY_MODE == 1) ? 1'b1 : (r_last_grant == GNT_I);
      else
         w_win_d = w_d_req;
   end

   // Next-state and next-output logic
   always_comb begin
      w_state        = r_state;
      w_grant        = r_grant;
      w_last_grant   = r_last_grant;
      w_is_write     = r_is_write;
      w_m_address    = r_m_address;
      w_m_writedata  = r_m_writedata;
      w_m_byteenable = r_m_byteenable;
      w_m_read       = r_m_read;
      w_m_write      = r_m_write;
      w_i_wait       = 1'b1;
      w_d_wait       = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (i_read || w_d_req) begin
               w_state      = ST_BUS;
               w_grant      = w_win_d ? GNT_D : GNT_I;
               w_last_grant = w_win_d ? GNT_D : GNT_I;
               if (w_win_d) begin
                  // Simultaneous read+write resolves to a write
                  w_is_write     = d_write;
                  w_m_address    = d_address;
                  w_m_writedata  = d_writedata;
                  w_m_byteenable = d_write ? d_byteenable : BW'(4'hF);
                  w_m_read       = ~d_write;
                  w_m_write      = d_write;
               end else begin
                  w_is_write     = 1'b0;
                  w_m_address    = i_address;
                  w_m_writedata  = '0;
                  w_m_byteenable = BW'(4'hF);
                  w_m_read       = 1'b1;
                  w_m_write      = 1'b0;
               end
            end
         end
         ST_BUS: begin
            if (!m_waitrequest) begin
               w_state   = ST_ACK;
               w_m_read  = 1'b0;
               w_m_write = 1'b0;
               w_i_wait  = (r_grant != GNT_I);
               w_d_wait  = (r_grant != GNT_D);
            end
         end
         ST_ACK: begin
            w_state = ST_IDLE;
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   assign i_waitrequest = r_i_wait;
   assign d_waitrequest = r_d_wait;
   assign m_address     = r_m_address;
   assign m_read        = r_m_read;
   assign m_write       = r_m_write;
   assign m_writedata   = r_m_writedata;
   assign m_byteenable  = r_m_byteenable;

   // Slave read data is forwarded straight through during the granted master's ACK
   assign i_readdata = (r_state == ST_ACK && r_grant == GNT_I) ? m_readdata : '0;
   assign d_readdata = (r_state == ST_ACK && r_grant == GNT_D && !r_is_write) ? m_readdata : '0;

endmodule

// File: doc/avalon_mem_arbiter.md
AVALON_MEM_ARBITER -- requirements
Module: avalon_mem_arbiter

Interface
REQ-001 Parameter PRIORITY_MODE, default 0, meaning: 0 = round-robin between masters, 1 = fixed priority with data master winning.
REQ-002 clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_address  input  32  instruction master byte address.
REQ-005 i_read  input  1  instruction master read request (read-only master).
REQ-006 i_waitrequest  output  1  low for exactly the completing cycle of an instruction transaction.
REQ-007 i_readdata  output  32  instruction read data, valid only while i_waitrequest is low.
REQ-008 d_address  input  32  data master byte address.
REQ-009 d_read, d_write  input  1 each  data master read and write requests.
REQ-010 d_writedata  input  32; d_byteenable  input  4  data master write payload and byte lanes.
REQ-011 d_waitrequest  output  1; d_readdata  output  32  same semantics as the instruction pair.
REQ-012 m_address  output  32; m_read, m_write  output  1; m_writedata  output  32; m_byteenable  output  4  shared slave command.
REQ-013 m_waitrequest  input  1; m_readdata  input  32  slave stall and read data (readdata valid the cycle after an accepted read).

Function
REQ-014 The FSM SHALL have the states IDLE, BUS and ACK, plus a 1-bit grant register (I/D) and a 1-bit last_grant register.
REQ-015 IDLE: if any request is present, choose a winner, latch its address/writedata/byteenable/op into the slave command registers, set grant, then go to BUS; with no request, remain in IDLE.
REQ-016 Tie, PRIORITY_MODE=0: the master not equal to last_grant wins; last_grant updates on every grant.
REQ-017 Tie, PRIORITY_MODE=1: the data master wins.
REQ-018 If only one master requests, that master wins in either mode.
REQ-019 If d_read and d_write are both high, a write SHALL be performed.
REQ-020 Data master writes use the latched d_byteenable; instruction reads and data reads drive m_byteenable=4'hF.
REQ-021 BUS: m_read or m_write is held high with a stable command.
- m_waitrequest high: stay in BUS, with no timeout.
- m_waitrequest low: go to ACK next cycle.
REQ-022 ACK: m_read=m_write=0; the granted master's waitrequest is low for exactly this one cycle; next state is IDLE.
REQ-023 In ACK, for a read, the granted master's readdata SHALL equal m_readdata combinationally; at all other times i_readdata and d_readdata are 32'h0.
REQ-024 m_read and m_write SHALL be high only in BUS, never simultaneously.
REQ-025 Master request inputs are sampled only in IDLE; changes during BUS/ACK are ignored.
REQ-026 Minimum latency SHALL be 3 cycles:
- cycle 0: request seen in IDLE;
- cycle 1: BUS (slave accepts);
- cycle 2: ACK.
Each extra m_waitrequest-high cycle adds 1.
REQ-027 A master re-requesting in the cycle after its ACK SHALL be arbitrated normally in IDLE, with no back-to-back bypass.
REQ-028 i_waitrequest and d_waitrequest are high in every cycle other than their own ACK, including while idle.
REQ-029 Address is passed unmodified; the arbiter does no address mapping.

Reset
REQ-030 While reset is high at a clock edge:
- state becomes IDLE and last_grant becomes D, so I wins the first round-robin tie;
- all m_* outputs become 0;
- both waitrequests become 1 and both readdata outputs 32'h0.
REQ-031 Reset asserted in BUS or ACK SHALL abandon the transaction with no ACK issued; m_read/m_write are low from the cycle after the reset edge.
REQ-032 Release of reset SHALL start arbitration in the first IDLE cycle after release.

Verification
REQ-033 Single I read: i_read=1, i_address=32'hBFC00000, m_waitrequest=0, slave returns 32'h3C011234 → m_read high at cycle 1 with m_address=32'hBFC00000; at cycle 2, i_waitrequest=0 and i_readdata=32'h3C011234.
REQ-034 Data write with lanes: d_write=1, d_address=32'h00000010, d_writedata=32'hAABBCCDD, d_byteenable=4'b0101 → m_write high for 1 cycle with m_byteenable=4'b0101; d_waitrequest low at cycle 2; i_waitrequest stays 1.
REQ-035 Slave stall: d_read with m_waitrequest held high 4 cycles → BUS lasts 5 cycles, ACK at cycle 6, and command signals are stable throughout BUS.
REQ-036 Round-robin tie, PRIORITY_MODE=0: both masters continuously requesting from reset → grants ordered I, D, I, D, and each ACK is 3 cycles apart.
REQ-037 Fixed-priority tie, PRIORITY_MODE=1: the same stimulus → D is granted every time and i_waitrequest never goes low.
REQ-038 Reset mid-BUS: reset pulsed for 1 cycle while m_waitrequest is high in BUS → next cycle m_read=0, no ACK occurs, and a pending i_read is granted in the first IDLE cycle after release.
